// File: rtl/vga_scanout_if.sv
// Frame buffer read port and VGA output bundle for vga_scanout.
// master = scanout engine, slave = frame buffer / display side.
interface vga_scanout_if;
    logic [15:0] fb_addr;
    logic        fb_rd;
    logic [7:0]  fb_data;
    logic        hsync;
    logic        vsync;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;
    logic        frame_start;

    modport master (
        output fb_addr, fb_rd, hsync, vsync, red, green, blue, frame_start,
        input  fb_data
    );

    modport slave (
        input  fb_addr, fb_rd, hsync, vsync, red, green, blue, frame_start,
        output fb_data
    );
endinterface

// File: rtl/vga_scanout.sv
// 640x480@60 1bpp frame buffer scanout: timing counters, fetch, pixel shift and registered VGA outputs.
// Optional macro TEST_PATTERN_EN adds test_sel, which replaces frame buffer pixels with an 8x8 checkerboard.
module vga_scanout #(
    parameter int          H_VIS    = 640,
    parameter int          H_FP     = 16,
    parameter int          H_SYNC   = 96,
    parameter int          H_BP     = 48,
    parameter int          V_VIS    = 480,
    parameter int          V_FP     = 10,
    parameter int          V_SYNC   = 2,
    parameter int          V_BP     = 33,
    parameter logic [11:0] FG_COLOR = 12'hFFF,
    parameter logic [11:0] BG_COLOR = 12'h000
) (
    input  logic         clock25,
    input  logic         reset_n,
`ifdef TEST_PATTERN_EN
    input  logic         test_sel,
`endif
    vga_scanout_if.master vga
);

    localparam int         H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int         V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_L  = 10'(H_VIS);
    localparam logic [9:0] V_VIS_L  = 10'(V_VIS);
    localparam logic [9:0] HS_FIRST = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_VIS + V_FP + V_SYNC - 1);

    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic        scan_run;

    logic        visible_s0;
    logic        fetch_s0;
    logic        hsync_s0;
    logic        vsync_s0;
    logic        first_s0;
    logic        fetch_block;
    logic [15:0] line_base;
    logic [15:0] fetch_addr;
    logic [15:0] addr_hold;
    logic [15:0] addr_c;

    logic        visible_s1;
    logic        hsync_s1;
    logic        vsync_s1;
    logic        first_s1;
    logic        load_s1;
    logic [7:0]  shift_reg;
    logic [7:0]  shift_next;
    logic        pixel_s1;

    logic [11:0] rgb;
    logic        hsync_q;
    logic        vsync_q;
    logic        frame_start_q;

    // scan_run keeps the counters at (0,0) for the first released edge so that
    // position (0,0) is the first one pushed down the pipeline after reset.
    always_ff @(posedge clock25) begin
        if (!reset_n) begin
            hcount   <= 10'd0;
            vcount   <= 10'd0;
            scan_run <= 1'b0;
        end else if (!scan_run) begin
            scan_run <= 1'b1;
        end else if (hcount == H_LAST) begin
            hcount <= 10'd0;
            vcount <= (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
        end else begin
            hcount <= hcount + 10'd1;
        end
    end

    always_comb begin
        visible_s0 = scan_run && (hcount < H_VIS_L) && (vcount < V_VIS_L);
        fetch_s0   = visible_s0 && (hcount[2:0] == 3'd0) && !fetch_block;
        hsync_s0   = !((hcount >= HS_FIRST) && (hcount <= HS_LAST));
        vsync_s0   = !((vcount >= VS_FIRST) && (vcount <= VS_LAST));
        first_s0   = scan_run && (hcount == 10'd0) && (vcount == 10'd0);
        line_base  = ({6'd0, vcount} << 6) + ({6'd0, vcount} << 4);
        fetch_addr = line_base + {9'd0, hcount[9:3]};
        addr_c     = fetch_s0 ? fetch_addr : addr_hold;
    end

    assign vga.fb_addr = addr_c;
    assign vga.fb_rd   = fetch_s0;

    // Read data lands in the cycle after a fetch; the output register samples the
    // shifter's next value so the first pixel of a byte is not delayed an extra cycle.
    always_comb begin
        shift_next = load_s1 ? vga.fb_data : {shift_reg[6:0], 1'b0};
    end

`ifdef TEST_PATTERN_EN
    logic pattern_s1;
    logic test_s1;

    assign fetch_block = test_sel;
    assign pixel_s1    = test_s1 ? pattern_s1 : shift_next[7];

    always_ff @(posedge clock25) begin
        if (!reset_n) begin
            pattern_s1 <= 1'b0;
            test_s1    <= 1'b0;
        end else begin
            pattern_s1 <= hcount[3] ^ vcount[3];
            test_s1    <= test_sel;
        end
    end
`else
    assign fetch_block = 1'b0;
    assign pixel_s1    = shift_next[7];
`endif

    always_ff @(posedge clock25) begin
        if (!reset_n) begin
            addr_hold     <= 16'd0;
            visible_s1    <= 1'b0;
            hsync_s1      <= 1'b1;
            vsync_s1      <= 1'b1;
            first_s1      <= 1'b0;
            load_s1       <= 1'b0;
            shift_reg     <= 8'd0;
            rgb           <= 12'h000;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            addr_hold     <= addr_c;
            visible_s1    <= visible_s0;
            hsync_s1      <= hsync_s0;
            vsync_s1      <= vsync_s0;
            first_s1      <= first_s0;
            load_s1       <= fetch_s0;
            shift_reg     <= shift_next;
            rgb           <= visible_s1 ? (pixel_s1 ? FG_COLOR : BG_COLOR) : 12'h000;
            hsync_q       <= hsync_s1;
            vsync_q       <= vsync_s1;
            frame_start_q <= first_s1;
        end
    end

    assign vga.red         = rgb[11:8];
    assign vga.green       = rgb[7:4];
    assign vga.blue        = rgb[3:0];
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.frame_start = frame_start_q;

endmodule
